// File: rtl/branch_predictor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_ctrl_if
// Brief    : Pipeline and bp_cache signal bundle for branch_predictor_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_ctrl_if #(
   parameter int AWIDTH = 30,
   parameter int CWIDTH = 32
);
   logic [31:0]       guess_pc;
   logic              guess_is_br;
   logic              guess_taken;
   logic              stall;
   logic              flush;
   logic              check_valid;
   logic [31:0]       check_pc;
   logic              check_taken;
   logic              check_pred;
   logic              check_mispredict;
   logic [AWIDTH-1:0] bp_ra0;
   logic [1:0]        bp_dout0;
   logic              bp_hit0;
   logic [AWIDTH-1:0] bp_ra1;
   logic [1:0]        bp_dout1;
   logic              bp_hit1;
   logic [AWIDTH-1:0] bp_wa;
   logic [1:0]        bp_din;
   logic              bp_we;
   logic              perf_clear;
   logic [CWIDTH-1:0] br_count;
   logic [CWIDTH-1:0] mispred_count;

   // Pipeline plus cache side
   modport master (
      output guess_pc, guess_is_br, stall, flush, check_valid, check_pc,
             check_taken, bp_dout0, bp_hit0, bp_dout1, bp_hit1, perf_clear,
      input  guess_taken, check_pred, check_mispredict, bp_ra0, bp_ra1,
             bp_wa, bp_din, bp_we, br_count, mispred_count
   );

   // Predictor control side
   modport slave (
      input  guess_pc, guess_is_br, stall, flush, check_valid, check_pc,
             check_taken, bp_dout0, bp_hit0, bp_dout1, bp_hit1, perf_clear,
      output guess_taken, check_pred, check_mispredict, bp_ra0, bp_ra1,
             bp_wa, bp_din, bp_we, br_count, mispred_count
   );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_ctrl
// Brief    : Fetch-time 2-bit counter prediction, execute-time check, counter
//            read-modify-write into bp_cache and branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_ctrl #(
   parameter int AWIDTH = 30,
   parameter int DELAY  = 2,
   parameter int CWIDTH = 32
) (
   input  wire                      clk,
   input  wire                      reset,
   branch_predictor_ctrl_if.slave   bus
);

   logic [DELAY-1:0]  r_valid;
   logic [DELAY-1:0]  r_taken;
   logic [CWIDTH-1:0] r_br_count;
   logic [CWIDTH-1:0] r_mispred_count;

   logic              w_guess_taken;
   logic              w_check_pred;
   logic              w_mispredict;
   logic              w_upd;
   logic [1:0]        w_new_ctr;
   wire               w_unused_pc_lsbs = &{1'b0, bus.guess_pc[1:0], bus.check_pc[1:0]};

   assign w_guess_taken = bus.guess_is_br & bus.bp_hit0 & bus.bp_dout0[1];
   assign w_check_pred  = ~reset & r_valid[DELAY-1] & r_taken[DELAY-1];
   assign w_mispredict  = bus.check_valid & (w_check_pred != bus.check_taken);
   assign w_upd         = bus.check_valid & ~bus.stall & ~reset;

   // Head is index 0, tail (instruction in execute) is index DELAY-1
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         r_taken <= '0;
      end else begin
         if (!bus.stall) begin
            r_taken[0] <= w_guess_taken;
            for (int i = 1; i < DELAY; i++) begin
               r_taken[i] <= r_taken[i-1];
            end
         end
         if (bus.flush) begin
            r_valid <= '0;
         end else if (!bus.stall) begin
            r_valid[0] <= bus.guess_is_br;
            for (int i = 1; i < DELAY; i++) begin
               r_valid[i] <= r_valid[i-1];
            end
         end
      end
   end

   // Saturating update on hit, weak allocation on miss
   always_comb begin
      w_new_ctr = 2'b00;
      if (w_upd) begin
         if (bus.bp_hit1) begin
            if (bus.check_taken) begin
               w_new_ctr = (bus.bp_dout1 == 2'b11) ? 2'b11 : bus.bp_dout1 + 2'd1;
            end else begin
               w_new_ctr = (bus.bp_dout1 == 2'b00) ? 2'b00 : bus.bp_dout1 - 2'd1;
            end
         end else begin
            w_new_ctr = bus.check_taken ? 2'b10 : 2'b01;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.perf_clear) begin
         r_br_count      <= '0;
         r_mispred_count <= '0;
      end else if (w_upd) begin
         r_br_count      <= r_br_count + 1'b1;
         r_mispred_count <= r_mispred_count + {{(CWIDTH-1){1'b0}}, w_mispredict};
      end
   end

   assign bus.guess_taken      = w_guess_taken;
   assign bus.check_pred       = w_check_pred;
   assign bus.check_mispredict = w_mispredict;
   assign bus.bp_ra0           = bus.guess_pc[AWIDTH+1:2];
   assign bus.bp_ra1           = bus.check_pc[AWIDTH+1:2];
   assign bus.bp_wa            = bus.check_pc[AWIDTH+1:2];
   assign bus.bp_din           = w_new_ctr;
   assign bus.bp_we            = w_upd;
   assign bus.br_count         = r_br_count;
   assign bus.mispred_count    = r_mispred_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_ctrl
// Brief    : Directed self-checking bench for branch_predictor_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_ctrl;
   localparam int c_AWIDTH = 30;
   localparam int c_DELAY  = 2;
   localparam int c_CWIDTH = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   branch_predictor_ctrl_if #(.AWIDTH(c_AWIDTH), .CWIDTH(c_CWIDTH)) bus ();

   branch_predictor_ctrl #(.AWIDTH(c_AWIDTH), .DELAY(c_DELAY), .CWIDTH(c_CWIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.guess_pc    = 32'h0;
      bus.guess_is_br = 1'b0;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      bus.check_valid = 1'b0;
      bus.check_pc    = 32'h0;
      bus.check_taken = 1'b0;
      bus.bp_dout0    = 2'b00;
      bus.bp_hit0     = 1'b0;
      bus.bp_dout1    = 2'b00;
      bus.bp_hit1     = 1'b0;
      bus.perf_clear  = 1'b0;
   endtask

   // Resolve one branch with the tail assumed invalid; check prediction and write
   task automatic resolve(input string tag, input logic hit, input logic [1:0] dout,
                          input logic taken, input logic [1:0] exp_din);
      bus.check_valid = 1'b1;
      bus.check_pc    = 32'h0000_2000;
      bus.bp_hit1     = hit;
      bus.bp_dout1    = dout;
      bus.check_taken = taken;
      #1;
      check({tag, "_din"}, {30'd0, bus.bp_din}, {30'd0, exp_din});
      check({tag, "_we"},  {31'd0, bus.bp_we}, 32'd1);
      tick();
      bus.check_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      reset = 1'b1;
      bus.check_valid = 1'b1;
      #1;
      check("rst_we", {31'd0, bus.bp_we}, 32'd0);
      check("rst_pred", {31'd0, bus.check_pred}, 32'd0);
      tick();
      tick();
      check("rst_br", {28'd0, bus.br_count}, 32'd0);
      check("rst_mis", {28'd0, bus.mispred_count}, 32'd0);
      reset = 1'b0;
      bus.check_valid = 1'b0;

      // Guess combinational behaviour
      bus.guess_is_br = 1'b1; bus.bp_hit0 = 1'b1; bus.bp_dout0 = 2'b10; #1;
      check("guess_hit10", {31'd0, bus.guess_taken}, 32'd1);
      bus.bp_dout0 = 2'b01; #1;
      check("guess_hit01", {31'd0, bus.guess_taken}, 32'd0);
      bus.guess_is_br = 1'b0; bus.bp_dout0 = 2'b11; #1;
      check("guess_notbr", {31'd0, bus.guess_taken}, 32'd0);

      // Cold miss
      bus.guess_is_br = 1'b1; bus.guess_pc = 32'h0000_1000; bus.bp_hit0 = 1'b0; #1;
      check("cold_guess", {31'd0, bus.guess_taken}, 32'd0);
      check("cold_ra0", {2'd0, bus.bp_ra0}, 32'h400);
      tick();
      bus.guess_is_br = 1'b0;
      tick();
      bus.check_valid = 1'b1; bus.check_pc = 32'h0000_1000;
      bus.check_taken = 1'b1; bus.bp_hit1 = 1'b0; #1;
      check("cold_pred", {31'd0, bus.check_pred}, 32'd0);
      check("cold_mis", {31'd0, bus.check_mispredict}, 32'd1);
      check("cold_we", {31'd0, bus.bp_we}, 32'd1);
      check("cold_wa", {2'd0, bus.bp_wa}, 32'h400);
      check("cold_ra1", {2'd0, bus.bp_ra1}, 32'h400);
      check("cold_din", {30'd0, bus.bp_din}, 32'd2);
      tick();
      bus.check_valid = 1'b0; #1;
      check("cold_br", {28'd0, bus.br_count}, 32'd1);
      check("cold_miscnt", {28'd0, bus.mispred_count}, 32'd1);
      check("idle_din", {30'd0, bus.bp_din}, 32'd0);

      // Correctly predicted taken branch
      bus.guess_is_br = 1'b1; bus.bp_hit0 = 1'b1; bus.bp_dout0 = 2'b11; #1;
      check("tk_guess", {31'd0, bus.guess_taken}, 32'd1);
      tick();
      bus.guess_is_br = 1'b0;
      tick();
      bus.check_valid = 1'b1; bus.check_taken = 1'b1;
      bus.bp_hit1 = 1'b1; bus.bp_dout1 = 2'b11; #1;
      check("tk_pred", {31'd0, bus.check_pred}, 32'd1);
      check("tk_mis", {31'd0, bus.check_mispredict}, 32'd0);
      check("sat_11", {30'd0, bus.bp_din}, 32'd3);
      tick();
      bus.check_valid = 1'b0;
      check("tk_br", {28'd0, bus.br_count}, 32'd2);
      check("tk_miscnt", {28'd0, bus.mispred_count}, 32'd1);

      // Counter transitions, tail invalid (1 mispredict among 4)
      resolve("sat_00", 1'b1, 2'b00, 1'b0, 2'b00);
      resolve("dec_10", 1'b1, 2'b10, 1'b0, 2'b01);
      resolve("inc_01", 1'b1, 2'b01, 1'b1, 2'b10);
      resolve("alloc_nt", 1'b0, 2'b11, 1'b0, 2'b01);
      check("tbl_br", {28'd0, bus.br_count}, 32'd6);
      check("tbl_miscnt", {28'd0, bus.mispred_count}, 32'd2);

      // Stall freezes delay line and counters
      bus.guess_is_br = 1'b1; bus.bp_hit0 = 1'b1; bus.bp_dout0 = 2'b10;
      tick();
      bus.guess_is_br = 1'b0; bus.stall = 1'b1; bus.check_valid = 1'b1;
      bus.check_taken = 1'b0; bus.bp_hit1 = 1'b1; bus.bp_dout1 = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_we", {31'd0, bus.bp_we}, 32'd0);
         check("stall_pred", {31'd0, bus.check_pred}, 32'd0);
         tick();
      end
      check("stall_br", {28'd0, bus.br_count}, 32'd6);
      bus.stall = 1'b0; #1;
      check("rel_we", {31'd0, bus.bp_we}, 32'd1);
      check("rel_din", {30'd0, bus.bp_din}, 32'd0);
      tick();
      check("rel_br", {28'd0, bus.br_count}, 32'd7);
      bus.check_taken = 1'b1; bus.bp_dout1 = 2'b10; #1;
      check("rel_pred", {31'd0, bus.check_pred}, 32'd1);
      check("rel_mis", {31'd0, bus.check_mispredict}, 32'd0);
      tick();
      bus.check_valid = 1'b0;
      check("rel_br2", {28'd0, bus.br_count}, 32'd8);
      check("rel_miscnt", {28'd0, bus.mispred_count}, 32'd2);

      // Flush kills two taken guesses
      bus.guess_is_br = 1'b1; bus.bp_hit0 = 1'b1; bus.bp_dout0 = 2'b11;
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0; bus.guess_is_br = 1'b0;
      bus.check_valid = 1'b1; bus.check_taken = 1'b1; bus.bp_hit1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("flush_pred", {31'd0, bus.check_pred}, 32'd0);
         check("flush_mis", {31'd0, bus.check_mispredict}, 32'd1);
         tick();
      end
      bus.check_valid = 1'b0;
      check("flush_br", {28'd0, bus.br_count}, 32'd10);
      check("flush_miscnt", {28'd0, bus.mispred_count}, 32'd4);

      // Wrap: 6 more updates takes the 4-bit count from 10 to 0
      bus.check_valid = 1'b1; bus.check_taken = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("wrap_br", {28'd0, bus.br_count}, 32'd0);
      check("wrap_miscnt", {28'd0, bus.mispred_count}, 32'd4);
      bus.check_taken = 1'b1; bus.perf_clear = 1'b1;
      tick();
      bus.perf_clear = 1'b0;
      check("clr_br", {28'd0, bus.br_count}, 32'd0);
      check("clr_miscnt", {28'd0, bus.mispred_count}, 32'd0);
      tick();
      bus.check_valid = 1'b0;
      check("post_clr_br", {28'd0, bus.br_count}, 32'd1);
      check("post_clr_mis", {28'd0, bus.mispred_count}, 32'd1);

      // Reset mid-flight
      bus.guess_is_br = 1'b1; bus.bp_hit0 = 1'b1; bus.bp_dout0 = 2'b11;
      tick();
      tick();
      reset = 1'b1; bus.guess_is_br = 1'b0; bus.check_valid = 1'b1; #1;
      check("mrst_we", {31'd0, bus.bp_we}, 32'd0);
      check("mrst_pred", {31'd0, bus.check_pred}, 32'd0);
      tick();
      reset = 1'b0; bus.check_valid = 1'b0; #1;
      check("mrst_pred1", {31'd0, bus.check_pred}, 32'd0);
      check("mrst_br", {28'd0, bus.br_count}, 32'd0);
      check("mrst_miscnt", {28'd0, bus.mispred_count}, 32'd0);
      tick();
      check("mrst_pred2", {31'd0, bus.check_pred}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/branch_predictor_ctrl.md
Name: branch_predictor_ctrl

Overview:
Control stage that sits between the CPU pipeline and bp_cache, the 2-bit-counter branch history cache, and drives every bp_cache port.
- In fetch it looks up the branch PC and issues a taken/not-taken guess.
- It carries that guess down a delay line to execute, compares it with the resolved outcome, and flags a mispredict.
- It performs the saturating counter read-modify-write back into bp_cache.
- It keeps branch and mispredict performance counters.

Parameters:
AWIDTH, 30, bp_cache address width; cache addresses are pc[31:2]
DELAY, 2, pipeline stages between guess (fetch) and check (execute); legal range 1..4
CWIDTH, 32, width of each performance counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
guess_pc  input  32  PC in fetch
guess_is_br  input  1  predecode: fetch instruction is a conditional branch
guess_taken  output  1  prediction for guess_pc (combinational)
stall  input  1  hold the pipeline: delay line frozen, no update, no counting
flush  input  1  kill in-flight younger instructions
check_valid  input  1  a conditional branch is resolving in execute this cycle
check_pc  input  32  PC of the resolving branch
check_taken  input  1  actual branch outcome
check_pred  output  1  guess previously issued for the resolving branch (combinational)
check_mispredict  output  1  check_valid & (check_pred != check_taken) (combinational)
bp_ra0  output  AWIDTH  = guess_pc[31:2]
bp_dout0  input  2  counter read for guess
bp_hit0  input  1  hit for guess lookup
bp_ra1  output  AWIDTH  = check_pc[31:2]
bp_dout1  input  2  counter read for update
bp_hit1  input  1  hit for update lookup
bp_wa  output  AWIDTH  = check_pc[31:2]
bp_din  output  2  new counter value
bp_we  output  1  counter write enable
perf_clear  input  1  synchronous clear of both performance counters
br_count  output  CWIDTH  resolved branches counted
mispred_count  output  CWIDTH  mispredicts counted

Behaviour:
- bp_cache contract: reads are combinational (dout/hit valid in the same cycle as ra); writes commit at the posedge when we=1.
- Guess: guess_taken = guess_is_br & bp_hit0 & bp_dout0[1]. A miss predicts not-taken.
- Delay line: DELAY entries of {valid, taken}.
  - When !stall, each clk shifts in {guess_is_br, guess_taken} at the head.
  - The tail entry belongs to the instruction in execute.
  - When stall, all entries hold.
- check_pred = tail.valid & tail.taken.
- Flush: at the clk edge, every entry's valid is cleared, including the one being shifted in. The tail in the flush cycle is still checked and updated normally. stall and flush together: flush wins for valid bits; taken bits hold.
- Update enable: upd = check_valid & !stall & !reset.
- Counter update while upd:
  - bp_hit1=1: taken -> saturating increment (11 stays 11); not taken -> saturating decrement (00 stays 00).
  - bp_hit1=0 (allocate): taken -> 10; not taken -> 01.
  - bp_we = upd; bp_din = new value.
  - bp_din is a don't-care when !upd; drive 00.
- Same-PC collision: guess_pc == check_pc in one cycle -> guess uses the pre-update counter (bp_dout0); no forwarding.
- Performance counters, updated at the clk edge while upd:
  - br_count += 1; mispred_count += check_mispredict.
  - Both wrap modulo 2^CWIDTH.
  - perf_clear zeroes both and has priority over increment.
- Reset: all delay-line entries invalid with taken=0; br_count = mispred_count = 0; bp_we = 0 combinationally while reset is high; check_pred = 0. bp_ra0/bp_ra1/bp_wa follow the PC inputs. Reset mid-operation discards all in-flight guesses; bp_cache contents are invalidated by bp_cache's own reset.
- No internal FSM beyond the delay line and counters. Target 150-250 lines of RTL.

Test Plan:
- Cold miss: reset; guess_is_br=1, guess_pc=0x0000_1000, bp_hit0=0 -> guess_taken=0. After DELAY cycles, check_valid=1, check_taken=1, bp_hit1=0 -> check_pred=0, check_mispredict=1, bp_we=1, bp_wa=0x400, bp_din=10; br_count=1, mispred_count=1.
- Saturation: hit with dout1=11, taken -> bp_din=11. Hit with dout1=00, not taken -> bp_din=00. Hit with dout1=10, not taken -> bp_din=01.
- Stall: assert stall for 3 cycles while check_valid=1 -> bp_we=0, counters and delay line unchanged. Release -> exactly one update and br_count +1.
- Flush: issue guesses taken=1 at t0 and t1, flush at t1 -> entries invalid. Their checks (check_valid=1, taken=1) give check_pred=0, check_mispredict=1.
- Counter wrap and clear: CWIDTH=4; 16 updates -> br_count wraps to 0. perf_clear coincident with upd -> both counters read 0 next cycle.
- Reset mid-flight: guesses in flight, pulse reset for 1 cycle -> check_pred=0, both counters 0, bp_we=0 during reset.
